// File: rtl/router_pkg.sv
// Shared defaults and types for the router destination port.
// The optional timeout flush is enabled by defining SOFT_RST_TIMEOUT_EN.
package router_pkg;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned TIMEOUT = 30;

    // One buffered byte plus its packet-header tag.
    typedef struct packed {
        logic             hdr;
        logic [WIDTH-1:0] data;
    } fifo_entry_t;

    // Elaboration-time helper for parameter sanity checks.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/dst_fifo_ram.sv
// Storage array for the destination FIFO: one synchronous write port,
// one asynchronous read port. No reset; contents are qualified by the pointers.
module dst_fifo_ram #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter type         entry_t = router_pkg::fifo_entry_t
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  entry_t            wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output entry_t            rd_data
);
    import router_pkg::*;

    entry_t mem [DEPTH];

    // Write the addressed entry on the clock edge.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_modport.sv
// Destination-side output port of the packet router: buffers bytes from the
// router core and hands them to one consumer over vld_out/read_enb/data_out.
// Define SOFT_RST_TIMEOUT_EN to flush the FIFO when vld_out goes unserviced
// for TIMEOUT consecutive cycles; otherwise soft_reset is tied low.
module router_modport #(
    parameter int unsigned WIDTH   = router_pkg::WIDTH,
    parameter int unsigned DEPTH   = router_pkg::DEPTH,
    parameter int unsigned TIMEOUT = router_pkg::TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_enb,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lfd_state,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             full,
    output logic             empty,
    output logic             soft_reset
);
    import router_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic             hdr;
        logic [WIDTH-1:0] data;
    } entry_t;

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("router_modport: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("router_modport: TIMEOUT must be >= 2");
    end

    // Pointers carry one extra MSB as a wrap flag to separate full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             do_wr, do_rd, flush;
    entry_t           wr_entry, rd_entry;
    logic             unused_hdr;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign vld_out  = !empty;
    assign data_out = data_out_q;

    assign wr_entry   = '{hdr: lfd_state, data: data_in};
    // The header tag is kept in storage for the core; the consumer only sees the byte.
    assign unused_hdr = rd_entry.hdr;

`ifdef SOFT_RST_TIMEOUT_EN
    localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive unserviced cycles; fire on the one that would reach TIMEOUT.
    always_comb begin
        flush = vld_out && !read_enb && (cnt_q == CntLast);
        cnt_d = cnt_q;
        if (empty || read_enb || flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign soft_reset = flush;
`else
    assign flush      = 1'b0;
    assign soft_reset = 1'b0;
`endif

    // Pointer and output-byte next state; a flush overrides both ports.
    always_comb begin
        do_wr      = write_enb && !full && !flush;
        do_rd      = read_enb && !empty && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
                data_out_d = rd_entry.data;
            end
        end
    end

    // Pointer and registered output-byte state.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    dst_fifo_ram #(
        .DEPTH   (DEPTH),
        .ADDR_W  (AW),
        .entry_t (entry_t)
    ) u_ram (
        .clock   (clock),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_router_modport.sv
// Self-checking bench for router_modport: directed scenarios plus a random
// phase, all compared against a queue-based model of the port.
module tb_router_modport;

    localparam int D  = 16;
    localparam int TO = 30;
`ifdef SOFT_RST_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       write_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lfd_state = 1'b0;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       vld_out, full, empty, soft_reset;

    router_modport dut (
        .clock      (clock),
        .reset      (reset),
        .write_enb  (write_enb),
        .data_in    (data_in),
        .lfd_state  (lfd_state),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .vld_out    (vld_out),
        .full       (full),
        .empty      (empty),
        .soft_reset (soft_reset)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] mq[$];
    logic [7:0] m_dout = 8'h00;
    int         m_run = 0;
    logic       last_soft = 1'b0;
    bit         saw_soft = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        mq.delete();
        m_dout = 8'h00;
        m_run  = 0;
    endtask

    // One clock of stimulus; outputs checked at the negedge against the model,
    // model advanced after the edge.
    task automatic cycle(input logic we, input logic [7:0] din, input logic lfd, input logic re);
        bit exp_soft;
        int sz;
        write_enb = we;
        data_in   = din;
        lfd_state = lfd;
        read_enb  = re;
        @(negedge clock);
        sz       = mq.size();
        exp_soft = TimeoutOn && (sz > 0) && !re && (m_run == TO - 1);
        check("empty", empty, sz == 0);
        check("full", full, sz == D);
        check("vld_out", vld_out, sz != 0);
        check("data_out", data_out, m_dout);
        check("soft_reset", soft_reset, exp_soft);
        last_soft = soft_reset;
        if (soft_reset) saw_soft = 1'b1;
        @(posedge clock);
        #1;
        if (exp_soft) begin
            mq.delete();
            m_run = 0;
        end else begin
            if (sz == 0 || re) m_run = 0;
            else m_run++;
            if (re && sz > 0) m_dout = mq.pop_front();
            if (we && sz < D) mq.push_back(din);
        end
        write_enb = 1'b0;
        read_enb  = 1'b0;
    endtask

    initial begin
        // 1. reset then idle
        do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_vld", vld_out, 0);
        check("rst_dout", data_out, 8'h00);
        check("rst_soft", soft_reset, 0);

        // 2. three bytes, header first
        cycle(1'b1, 8'h41, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_rd0", data_out, 8'h41);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_rd1", data_out, 8'h11);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_rd2", data_out, 8'h22);
        check("t2_vld_drop", vld_out, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_rd_empty_hold", data_out, 8'h22);

        // 3. fill, dropped overflow write, drain
        for (int i = 0; i < D; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        check("t3_full", full, 1);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        check("t3_still_full", full, 1);
        for (int i = 0; i < D; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            check("t3_drain", data_out, 8'(8'h10 + i));
        end
        check("t3_empty", empty, 1);

        // 4. pointer wrap
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            check("t4_wrap", data_out, 8'(8'h80 + i));
        end
        check("t4_empty", empty, 1);

        // 5. full with simultaneous write and read
        for (int i = 0; i < D; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        check("t5_full_clear", full, 0);
        check("t5_rd", data_out, 8'hA0);
        for (int i = 1; i < D; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_last", data_out, 8'hAF);
        check("t5_empty", empty, 1);

        // 6. timeout behaviour
        do_reset();
        saw_soft = 1'b0;
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        if (TimeoutOn) begin
            for (int k = 1; k < TO; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
            check("t6_no_early", saw_soft, 0);
            cycle(1'b1, 8'h77, 1'b0, 1'b0);
            check("t6_pulse_30", last_soft, 1);
            check("t6_flushed", empty, 1);
            check("t6_dout_kept", data_out, 8'h00);
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            check("t6_one_cycle", last_soft, 0);
            saw_soft = 1'b0;
            cycle(1'b1, 8'h5B, 1'b0, 1'b0);
            for (int k = 1; k < TO - 1; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            for (int k = 0; k < 5; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
            check("t6_serviced_no_pulse", saw_soft, 0);
            check("t6_serviced_dout", data_out, 8'h5B);
        end else begin
            for (int k = 0; k < 40; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
            check("t6_never_soft", saw_soft, 0);
            check("t6_still_vld", vld_out, 1);
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            check("t6_byte_kept", data_out, 8'h5A);
        end

        // 7. random traffic with phases biased toward full and toward empty
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int wp, rp;
            case (i / 100)
                0:       begin wp = 80; rp = 20; end
                1:       begin wp = 20; rp = 80; end
                default: begin wp = 50; rp = 50; end
            endcase
            cycle(($urandom_range(99) < wp), 8'($urandom), 1'($urandom), ($urandom_range(99) < rp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
